// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display controller: glyph table and FSM states.
// Glyphs are active-high {a,b,c,d,e,f,g,dp}; the DP bit is always clear in the table.
package seg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } seg_state_t;

    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_DASH  = 8'h02;

    localparam logic [7:0] GLYPH_0 = 8'hFC;
    localparam logic [7:0] GLYPH_1 = 8'h60;
    localparam logic [7:0] GLYPH_2 = 8'hDA;
    localparam logic [7:0] GLYPH_3 = 8'hF2;
    localparam logic [7:0] GLYPH_4 = 8'h66;
    localparam logic [7:0] GLYPH_5 = 8'hB6;
    localparam logic [7:0] GLYPH_6 = 8'hBE;
    localparam logic [7:0] GLYPH_7 = 8'hE0;
    localparam logic [7:0] GLYPH_8 = 8'hFE;
    localparam logic [7:0] GLYPH_9 = 8'hF6;
    localparam logic [7:0] GLYPH_A = 8'hEE;
    localparam logic [7:0] GLYPH_B = 8'h3E;
    localparam logic [7:0] GLYPH_C = 8'h9C;
    localparam logic [7:0] GLYPH_D = 8'h7A;
    localparam logic [7:0] GLYPH_E = 8'h9E;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    function automatic logic [7:0] glyph_of(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Nibble to active-high 7-segment glyph decoder (DP bit left clear).
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] glyph_o
);

    assign glyph_o = glyph_of(nib_i);

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: hex or decimal (sequential double-dabble) display with
// leading-zero blanking and DP masks. Define SEG_BLINK_EN to build the per-digit blink counter.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int BLINK_DIV  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_dec,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [8*NUM_DIGITS-1:0] o_seg
);

    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    seg_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIG_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic              shown_q, shown_d;
    logic              ovf_q, ovf_d;

    logic [DIG_W-1:0]  bcd_adj;
    logic [DIG_W-1:0]  bcd_shift;
    logic              bcd_carry;
    logic              blink_phase;

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[DIG_W-2:0], shift_q[DATA_W-1]};
    assign bcd_carry = bcd_adj[DIG_W-1];
    assign in_ready  = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digit_d    = digit_q;
        shown_d    = shown_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_dec) begin
                        state_d    = CONV;
                        shift_d    = in_data;
                        bcd_d      = '0;
                        cnt_d      = '0;
                        ovf_pend_d = 1'b0;
                    end else begin
                        digit_d = DIG_W'(in_data);
                        shown_d = 1'b1;
                        ovf_d   = 1'b0;
                    end
                end
            end
            CONV: begin
                bcd_d      = bcd_shift;
                shift_d    = shift_q << 1;
                cnt_d      = cnt_q + CNT_W'(1);
                ovf_pend_d = ovf_pend_q | bcd_carry;
                if (cnt_q == LAST_CNT) begin
                    digit_d = bcd_shift;
                    ovf_d   = ovf_pend_q | bcd_carry;
                    shown_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digit_q    <= '0;
            shown_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digit_q    <= digit_d;
            shown_q    <= shown_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SEG_BLINK_EN
    logic [BLINK_DIV-1:0] blink_q, blink_d;

    assign blink_d     = blink_q + BLINK_DIV'(1);
    assign blink_phase = blink_q[BLINK_DIV-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_DIV > 0);
    assign blink_phase      = 1'b0;
`endif

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [7:0] glyph_raw;
            logic [7:0] glyph;
            logic       keep;

            seg_glyph_dec u_dec (
                .nib_i   (digit_q[4*gi +: 4]),
                .glyph_o (glyph_raw)
            );

            // Digit 0 always shows, so a zero value reads "0" rather than all blank.
            if (gi == 0) begin : g_keep0
                assign keep = 1'b1;
            end else begin : g_keepn
                assign keep = |digit_q[DIG_W-1:4*gi];
            end

            always_comb begin
                glyph = GLYPH_BLANK;
                if (shown_q) begin
                    if (ovf_q) begin
                        glyph = GLYPH_DASH;
                    end else if (lz_blank && !keep) begin
                        glyph = GLYPH_BLANK;
                    end else begin
                        glyph = glyph_raw;
                    end
                    glyph[0] = dp_mask[gi];
                end
                if (blink_phase && blink_mask[gi]) begin
                    glyph = GLYPH_BLANK;
                end
            end

            assign o_seg[8*gi +: 8] = ~glyph;
        end
    endgenerate

endmodule
